// File: rtl/note_judge.sv
// note_judge: per-lane hit/miss judge for the falling-note piano game.
// Key levels are synchronised and turned into one-cycle press edges. Each of
// the three lanes runs a small FSM that judges one block per pass through the
// hit window. It emits a stretched add or wrong pulse, followed by a quiet gap,
// so the downstream controller always sees a clean rising edge.
module note_judge #(
  parameter int KEYS      = 16,
  parameter int Y_W       = 10,
  parameter int HIT_TOP   = 400,
  parameter int HIT_BOT   = 440,
  parameter int PULSE_LEN = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ena,
  input  logic [2:0]     ena_block,
  input  logic [15:0]    keys,
  input  logic [Y_W-1:0] block_y0,
  input  logic [Y_W-1:0] block_y1,
  input  logic [Y_W-1:0] block_y2,
  input  logic [3:0]     block_key0,
  input  logic [3:0]     block_key1,
  input  logic [3:0]     block_key2,
  output logic [2:0]     add,
  output logic [2:0]     wrong,
  output logic [3:0]     down_target0,
  output logic [3:0]     down_target1,
  output logic [3:0]     down_target2
);

  localparam int          LANES   = 3;
  localparam logic [7:0]  PL_LAST = 8'(PULSE_LEN - 1);
  localparam logic [Y_W-1:0] Y_TOP = Y_W'(HIT_TOP);
  localparam logic [Y_W-1:0] Y_BOT = Y_W'(HIT_BOT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WINDOW,
    S_HIT,
    S_WRONG,
    S_GAP,
    S_DONE
  } state_t;

  // Key path registers: two synchroniser flops, a delayed copy, and the edge.
  logic [KEYS-1:0] sync1_q;
  logic [KEYS-1:0] sync2_q;
  logic [KEYS-1:0] prev_q;
  logic [KEYS-1:0] edge_q;

  // Per-lane state.
  state_t     st_q  [LANES];
  state_t     st_d  [LANES];
  logic [7:0] cnt_q [LANES];
  logic [7:0] cnt_d [LANES];
  logic [3:0] bk_q  [LANES];
  logic [3:0] bk_d  [LANES];
  logic [3:0] dt_q  [LANES];
  logic [3:0] dt_d  [LANES];
  logic [2:0] add_q;
  logic [2:0] add_d;
  logic [2:0] wrong_q;
  logic [2:0] wrong_d;

  // Lane inputs gathered into arrays so the lane logic can be written once.
  logic [Y_W-1:0]  y_in    [LANES];
  logic [3:0]      key_in  [LANES];
  logic [LANES-1:0] in_win;
  logic [LANES-1:0] past_win;
  logic [LANES-1:0] above_win;
  logic [KEYS-1:0] excl    [LANES];
  logic [KEYS-1:0] cand    [LANES];
  logic [3:0]      cand_lo [LANES];

  assign y_in[0]   = block_y0;
  assign y_in[1]   = block_y1;
  assign y_in[2]   = block_y2;
  assign key_in[0] = block_key0;
  assign key_in[1] = block_key1;
  assign key_in[2] = block_key2;

  // ---- stage p0 -> p1: key synchroniser and press-edge detection ----
  // Synchronise the asynchronous key levels and register a one-cycle press edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      edge_q  <= '0;
    end else begin
      sync1_q <= keys;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      edge_q  <= sync2_q & ~prev_q;
    end
  end

  // Y window comparisons (unsigned) for every lane.
  always_comb begin
    in_win    = '0;
    past_win  = '0;
    above_win = '0;
    for (int i = 0; i < LANES; i++) begin
      in_win[i]    = (y_in[i] >= Y_TOP) && (y_in[i] <= Y_BOT);
      past_win[i]  = (y_in[i] > Y_BOT);
      above_win[i] = (y_in[i] < Y_TOP);
    end
  end

  // Wrong-key candidates: presses other than our own target, excluding keys
  // that another lane currently in WINDOW is waiting for; pick the lowest.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      excl[i]    = '0;
      cand[i]    = '0;
      cand_lo[i] = '0;
    end
    for (int i = 0; i < LANES; i++) begin
      for (int j = 0; j < LANES; j++) begin
        if (j != i && st_q[j] == S_WINDOW) begin
          excl[i][bk_q[j]] = 1'b1;
        end
      end
      excl[i][bk_q[i]] = 1'b1;
      cand[i] = edge_q & ~excl[i];
      for (int k = KEYS - 1; k >= 0; k--) begin
        if (cand[i][k]) begin
          cand_lo[i] = 4'(k);
        end
      end
    end
  end

  // ---- stage p1 -> p2: lane judgement FSMs ----
  // Next-state and pulse logic for each lane.
  always_comb begin
    add_d   = '0;
    wrong_d = '0;
    for (int i = 0; i < LANES; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      bk_d[i]  = bk_q[i];
      dt_d[i]  = dt_q[i];
      if (!(ena && ena_block[i])) begin
        // Disabled lane drops any pulse immediately but keeps its last target.
        st_d[i]  = S_IDLE;
        cnt_d[i] = '0;
      end else begin
        unique case (st_q[i])
          S_IDLE: begin
            if (in_win[i]) begin
              st_d[i] = S_WINDOW;
              bk_d[i] = key_in[i];
            end
          end
          S_WINDOW: begin
            if (edge_q[bk_q[i]]) begin
              st_d[i]  = S_HIT;
              dt_d[i]  = bk_q[i];
              cnt_d[i] = '0;
              add_d[i] = 1'b1;
            end else if (|cand[i]) begin
              st_d[i]    = S_WRONG;
              dt_d[i]    = cand_lo[i];
              cnt_d[i]   = '0;
              wrong_d[i] = 1'b1;
            end else if (past_win[i]) begin
              st_d[i]    = S_WRONG;
              dt_d[i]    = bk_q[i];
              cnt_d[i]   = '0;
              wrong_d[i] = 1'b1;
            end
          end
          S_HIT: begin
            if (cnt_q[i] == PL_LAST) begin
              st_d[i]  = S_GAP;
              cnt_d[i] = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + 8'd1;
              add_d[i] = 1'b1;
            end
          end
          S_WRONG: begin
            if (cnt_q[i] == PL_LAST) begin
              st_d[i]  = S_GAP;
              cnt_d[i] = '0;
            end else begin
              cnt_d[i]   = cnt_q[i] + 8'd1;
              wrong_d[i] = 1'b1;
            end
          end
          S_GAP: begin
            if (cnt_q[i] == PL_LAST) begin
              st_d[i]  = S_DONE;
              cnt_d[i] = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + 8'd1;
            end
          end
          S_DONE: begin
            // Wait for the block to respawn above the window.
            if (above_win[i]) begin
              st_d[i] = S_IDLE;
            end
          end
          default: begin
            st_d[i]  = S_IDLE;
            cnt_d[i] = '0;
          end
        endcase
      end
    end
  end

  // Lane state, counters, latched targets and registered output pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < LANES; i++) begin
        st_q[i]  <= S_IDLE;
        cnt_q[i] <= '0;
        bk_q[i]  <= '0;
        dt_q[i]  <= '0;
      end
      add_q   <= '0;
      wrong_q <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
        bk_q[i]  <= bk_d[i];
        dt_q[i]  <= dt_d[i];
      end
      add_q   <= add_d;
      wrong_q <= wrong_d;
    end
  end

  assign add          = add_q;
  assign wrong        = wrong_q;
  assign down_target0 = dt_q[0];
  assign down_target1 = dt_q[1];
  assign down_target2 = dt_q[2];

endmodule

// File: tb/tb_note_judge.sv
// Testbench for note_judge: scripted lane scenarios with a scoreboard of
// expected add/wrong pulses checked by a monitor on the falling clock edge.
module tb_note_judge;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [2:0]  ena_block;
  logic [15:0] keys;
  logic [9:0]  block_y0, block_y1, block_y2;
  logic [3:0]  block_key0, block_key1, block_key2;
  logic [2:0]  add, wrong;
  logic [3:0]  down_target0, down_target1, down_target2;

  note_judge dut (
    .clk(clk), .rst(rst), .ena(ena), .ena_block(ena_block), .keys(keys),
    .block_y0(block_y0), .block_y1(block_y1), .block_y2(block_y2),
    .block_key0(block_key0), .block_key1(block_key1), .block_key2(block_key2),
    .add(add), .wrong(wrong),
    .down_target0(down_target0), .down_target1(down_target1),
    .down_target2(down_target2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lane;
    int kind;   // 0 = add, 1 = wrong
    int tgt;
    int start;
    int len;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  logic [2:0] prevp = '0;
  int  run [3];
  int  exp_len [3];
  int  last_rise [3];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_ev(input int lane, input int kind, input int tgt,
                         input int start, input int len);
    ev_t e;
    e.lane = lane; e.kind = kind; e.tgt = tgt; e.start = start; e.len = len;
    exp_q.push_back(e);
  endtask

  function automatic int dtv(input int l);
    case (l)
      0: return int'(down_target0);
      1: return int'(down_target1);
      default: return int'(down_target2);
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: match each rising pulse against the scoreboard, check its length.
  always @(negedge clk) begin
    ev_t e;
    logic p;
    for (int l = 0; l < 3; l++) begin
      p = add[l] | wrong[l];
      if (p && !prevp[l]) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", 32'd1, 32'd0);
          exp_len[l] = 4;
        end else begin
          e = exp_q.pop_front();
          chk("lane", l, e.lane);
          chk("kind", {31'd0, wrong[l]}, e.kind);
          chk("target", dtv(l), e.tgt);
          chk("start", cyc, e.start);
          exp_len[l] = e.len;
        end
        if (last_rise[l] >= 0) chk("spacing_ge8", {31'd0, (cyc - last_rise[l]) >= 8}, 32'd1);
        last_rise[l] = cyc;
        run[l] = 1;
      end else if (p) begin
        run[l]++;
      end else if (prevp[l]) begin
        chk("pulse_len", run[l], exp_len[l]);
      end
      prevp[l] = p;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    for (int l = 0; l < 3; l++) begin
      run[l] = 0; exp_len[l] = 4; last_rise[l] = -1;
    end
    rst = 1'b0; ena = 1'b0; ena_block = 3'b000; keys = '0;
    block_y0 = '0; block_y1 = '0; block_y2 = '0;
    block_key0 = '0; block_key1 = '0; block_key2 = '0;
    tick(3);
    chk("rst_add", add, 0);
    chk("rst_wrong", wrong, 0);
    chk("rst_dt0", down_target0, 0);
    chk("rst_dt1", down_target1, 0);
    chk("rst_dt2", down_target2, 0);
    rst = 1'b1;

    // Hit on lane 0.
    ena = 1'b1; ena_block = 3'b001; block_key0 = 4'd5; block_y0 = 10'd390;
    tick(2);
    block_y0 = 10'd420;
    tick(2);
    c = cyc; keys[5] = 1'b1; push_ev(0, 0, 5, c + 4, 4);
    tick(12);
    chk("hit_dt0", down_target0, 5);
    keys = '0; tick(4);
    block_y0 = 10'd100; tick(2);

    // Wrong key, later correct press on the same block ignored.
    block_y0 = 10'd420; tick(2);
    c = cyc; keys[9] = 1'b1; push_ev(0, 1, 9, c + 4, 4);
    tick(6); keys = '0; tick(2);
    keys[5] = 1'b1; tick(10);
    chk("wrongkey_dt0", down_target0, 9);
    keys = '0; block_y0 = 10'd100; tick(4);

    // Miss: block slides past the window bottom; HIT_BOT itself is inside.
    block_key0 = 4'd12; block_y0 = 10'd420; tick(2);
    block_y0 = 10'd440; tick(2);
    c = cyc; block_y0 = 10'd441; push_ev(0, 1, 12, c + 1, 4);
    tick(12);
    chk("miss_dt0", down_target0, 12);
    block_y0 = 10'd460; tick(5);
    block_y0 = 10'd430; tick(5);
    block_y0 = 10'd100; tick(2);

    // Two lanes hit on the same cycle; HIT_TOP is inside the window.
    ena_block = 3'b011; block_key0 = 4'd3; block_key1 = 4'd7;
    block_y0 = 10'd420; block_y1 = 10'd400; tick(2);
    c = cyc; keys[3] = 1'b1; keys[7] = 1'b1;
    push_ev(0, 0, 3, c + 4, 4); push_ev(1, 0, 7, c + 4, 4);
    tick(12);
    chk("dual_dt1", down_target1, 7);
    keys = '0; block_y0 = 10'd100; block_y1 = 10'd100; tick(2);

    // Lane 1's target pressed: not a wrong key for lane 0, which then misses.
    block_y0 = 10'd420; block_y1 = 10'd420; tick(2);
    c = cyc; keys[7] = 1'b1; push_ev(1, 0, 7, c + 4, 4);
    tick(6); keys = '0; tick(6);
    c = cyc; block_y0 = 10'd441; push_ev(0, 1, 3, c + 1, 4);
    tick(12);
    chk("excl_dt0", down_target0, 3);
    block_y0 = 10'd100; block_y1 = 10'd100; ena_block = 3'b001; tick(2);

    // Back-to-back blocks on lane 0.
    block_key0 = 4'd5; block_y0 = 10'd420; tick(2);
    c = cyc; keys[5] = 1'b1; push_ev(0, 0, 5, c + 4, 4);
    tick(2); keys = '0; tick(10);
    block_y0 = 10'd100; tick(1);
    c = cyc; block_y0 = 10'd420; keys[5] = 1'b1; push_ev(0, 0, 5, c + 4, 4);
    tick(12);
    keys = '0; block_y0 = 10'd100; tick(4);

    // ena drops in the second cycle of a hit pulse.
    block_y0 = 10'd420; tick(2);
    c = cyc; keys[5] = 1'b1; push_ev(0, 0, 5, c + 4, 2);
    tick(5);
    ena = 1'b0; block_y0 = 10'd100; tick(1);
    chk("ena_drop_add", add, 0);
    chk("ena_drop_dt0", down_target0, 5);
    keys = '0; tick(2); ena = 1'b1; tick(12);

    // Reset asserted during a wrong pulse.
    block_key0 = 4'd6; block_y0 = 10'd420; tick(2);
    c = cyc; keys[9] = 1'b1; push_ev(0, 1, 9, c + 4, 2);
    tick(5);
    rst = 1'b0; tick(1);
    chk("rst_mid_add", add, 0);
    chk("rst_mid_wrong", wrong, 0);
    chk("rst_mid_dt0", down_target0, 0);
    rst = 1'b1; keys = '0; block_y0 = 10'd100; tick(12);

    // Key bounce inside the window gives one hit.
    block_key0 = 4'd5; block_y0 = 10'd420; tick(2);
    c = cyc; keys[5] = 1'b1; push_ev(0, 0, 5, c + 4, 4);
    tick(1); keys = '0; tick(1); keys[5] = 1'b1;
    tick(12);
    chk("bounce_dt0", down_target0, 5);
    keys = '0; block_y0 = 10'd100; tick(10);

    chk("pending_events", exp_q.size(), 0);
    chk("open_pulses", {29'd0, add | wrong}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/note_judge.md
Name: note_judge

Overview:
- Judge stage that sits directly upstream of the score/level controller in the piano game.
- Each of three falling-note lanes reports a block Y position and a target key. The block compares player key presses against the hit window.
- Per lane it emits one stretched add (hit) or wrong (miss / wrong key) pulse, plus the 4-bit key index blamed for the event.
- Outputs feed the controller's add[2:0], wrong[2:0] and down_target0..2, which the controller uses as edge-triggered strobes. Pulses are therefore stretched and separated.

Parameters:
- KEYS, 16, number of piano keys; key index width is 4.
- Y_W, 10, block Y coordinate width (pixels, 0 = top of screen).
- HIT_TOP, 400, first Y line of the hit window (inclusive).
- HIT_BOT, 440, last Y line of the hit window (inclusive).
- PULSE_LEN, 4, cycles an add/wrong pulse is held high; 1..255.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- ena  in  1  game running; 0 = judging disabled.
- ena_block  in  3  lane enables from the controller.
- keys  in  16  raw key levels, asynchronous, 1 = pressed.
- block_y0, block_y1, block_y2  in  10  current top Y of each lane's falling block.
- block_key0, block_key1, block_key2  in  4  key index the lane's block requires.
- add  out  3  per-lane hit pulse.
- wrong  out  3  per-lane miss/wrong-key pulse.
- down_target0, down_target1, down_target2  out  4  key index for the lane's last event.

Behaviour:
- **Clock and reset**
  - One clock domain. Reset is synchronous and active-low: the block resets only on a clk edge with rst=0.
  - Reset values: add=0, wrong=0, down_target*=0, all lanes in IDLE, pulse counters 0, key synchronizer and edge registers 0.
- **Key input path**
  - 2-flop synchronizer on keys, then a registered copy. edge[k] = sync[k] & ~prev[k].
  - Latency from a key pin to edge: 3 clk edges.
- **Lane state machine** (lane i independent; states IDLE, WINDOW, HIT, WRONG, GAP, DONE)
  - IDLE: if ena & ena_block[i] & HIT_TOP <= y_i <= HIT_BOT, go to WINDOW. Latch bk_i = block_key_i.
  - WINDOW, checks in priority order:
    - (a) edge[bk_i]=1: go to HIT, down_target_i <= bk_i.
    - (b) any other edge bit set, and that key is not the latched target of another lane currently in WINDOW: go to WRONG, down_target_i <= lowest such key index.
    - (c) y_i > HIT_BOT: go to WRONG, down_target_i <= bk_i (miss).
    - Otherwise hold in WINDOW.
  - HIT: add[i]=1 for exactly PULSE_LEN cycles, then go to GAP.
  - WRONG: wrong[i]=1 for exactly PULSE_LEN cycles, then go to GAP.
  - GAP: add[i]=wrong[i]=0 for PULSE_LEN cycles, then go to DONE. This guarantees the controller sees distinct rising edges.
  - DONE: stay until y_i < HIT_TOP (block respawned at top), then go to IDLE. Exactly one judgement per block.
- **Output timing**
  - add/wrong assert on the clk edge that enters HIT/WRONG. There is one cycle between the edge bit and the pulse.
  - down_target_i changes only on entry to HIT/WRONG. It is held otherwise, including through GAP and DONE.
- **Simultaneous and boundary cases**
  - A correct edge plus any wrong edges in the same cycle counts as a hit.
  - Edge (a) and miss condition (c) in the same cycle counts as a hit.
  - One key matching the targets of two lanes in WINDOW scores a hit in both lanes.
  - y exactly HIT_TOP or HIT_BOT is inside the window.
  - Key edges in IDLE/HIT/WRONG/GAP/DONE are ignored by that lane.
  - A block entering the window while the lane is in GAP/DONE is not judged.
- **Enable handling**
  - ena=0 or ena_block[i]=0: lane i goes to IDLE on the next edge and add[i]/wrong[i] drop to 0, even mid-pulse. down_target_i is held.
  - Reset asserted mid-pulse clears the pulse on that edge.
- **Counters and comparisons**
  - Pulse/gap counter is 8 bits per lane and counts 0..PULSE_LEN-1; no wrap is possible.
  - Y comparisons are unsigned Y_W-bit.

Test Plan:
- Reset release, ena=1, ena_block=001; y0 steps 390 to 420, block_key0=5, keys[5] rises → add=001 for exactly 4 cycles starting 4 cycles after the key edge; down_target0=5; wrong=000.
- Lane0 in window, target 5, keys[9] rises → wrong=001 for 4 cycles, down_target0=9. A later keys[5] press on the same block gives no add.
- Lane0 enters window with no press, y0 goes 440 → 441 → wrong[0] high for 4 cycles, down_target0=block_key0. No further pulse until y0<400 and the block re-enters.
- ena_block=011, lanes 0 and 1 in window with targets 3 and 7; keys[3] and keys[7] rise in the same cycle → add=011, wrong=000. Then back-to-back blocks on lane0 → rising edges of add[0] separated by ≥8 cycles.
- add[0] high in cycle 2 of its pulse, then ena drops → add=000 next edge, lane IDLE. rst=0 for one edge during a wrong pulse → all outputs 0 on that edge.
- Key bounce: keys[5] toggles 1 cycle high, 1 low, 1 high inside the window → exactly one add pulse of 4 cycles.
